// File: rtl/freq_gen_pkg.sv
// Shared types and default widths for the multi-channel frequency generator.
package freq_gen_pkg;

  // Output mode of one channel. Config codes 2 and 3 both map to MODE_OFF.
  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_OFF    = 2'd2
  } mode_e;

  localparam int DefAccWidth = 16;
  localparam int DefNumCh    = 4;

  // Map the raw 2-bit config code onto a mode.
  function automatic mode_e decode_mode(input logic [1:0] code);
    case (code)
      2'd0:    return MODE_SQUARE;
      2'd1:    return MODE_PULSE;
      default: return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator, active and pending config, registered
// output and wrap tick. Pending config is swapped in only at a wrap (or when
// the channel is idle) so period changes never produce a runt pulse.
module nco_channel
  import freq_gen_pkg::*;
#(
  parameter int AccWidth = DefAccWidth
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_load,
  input  logic [AccWidth-1:0] cfg_step,
  input  logic [AccWidth-1:0] cfg_phase,
  input  mode_e               cfg_mode,
  output logic                pending,
  output logic                clk_out,
  output logic                tick
);

  logic [AccWidth-1:0] acc;
  logic [AccWidth-1:0] step_a;
  logic [AccWidth-1:0] phase_a;
  mode_e               mode_a;
  logic [AccWidth-1:0] step_p;
  logic [AccWidth-1:0] phase_p;
  mode_e               mode_p;

  logic [AccWidth:0]   sum;
  logic                carry;
  logic [AccWidth-1:0] phased;
  logic                apply;

  // Accumulator add, phase-shifted view and the pending-apply qualifier.
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, step_a};
    carry  = sum[AccWidth];
    phased = acc + phase_a;
    apply  = pending && (!en || (mode_a == MODE_OFF) || (step_a == '0) || carry);
  end

  // Channel state: accumulator, config registers and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      acc     <= '0;
      step_a  <= '0;
      phase_a <= '0;
      mode_a  <= MODE_OFF;
      step_p  <= '0;
      phase_p <= '0;
      mode_p  <= MODE_OFF;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (en) begin
        acc  <= sum[AccWidth-1:0];
        tick <= carry;
      end else begin
        tick <= 1'b0;
      end

      case (mode_a)
        MODE_SQUARE: if (en) clk_out <= phased[AccWidth-1];
        MODE_PULSE:  clk_out <= en & carry;
        default:     clk_out <= 1'b0;
      endcase

      // Load and apply are mutually exclusive: a load needs pending clear,
      // so a config accepted on a wrap cycle waits for the next wrap.
      if (apply) begin
        step_a  <= step_p;
        phase_a <= phase_p;
        mode_a  <= mode_p;
        pending <= 1'b0;
      end else if (cfg_load) begin
        step_p  <= cfg_step;
        phase_p <= cfg_phase;
        mode_p  <= cfg_mode;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_freq_gen.sv
// Multi-channel frequency generator top: config decode and cfg_ready only;
// all timing state lives in the per-channel nco_channel instances.
module multi_freq_gen
  import freq_gen_pkg::*;
#(
  parameter int AccWidth = DefAccWidth,
  parameter int NumCh    = DefNumCh,
  parameter int ChW      = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NumCh-1:0]    en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ChW-1:0]      cfg_ch,
  input  logic [AccWidth-1:0] cfg_step,
  input  logic [AccWidth-1:0] cfg_phase,
  input  logic [1:0]          cfg_mode,
  output logic [NumCh-1:0]    clk_out,
  output logic [NumCh-1:0]    tick
);

  logic [NumCh-1:0] pend;
  logic [NumCh-1:0] load;
  mode_e            mode_dec;

  // Ready drops only for an in-range channel that already holds a pending
  // config; out-of-range targets are accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    load      = '0;
    mode_dec  = decode_mode(cfg_mode);
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (cfg_ch == ChW'(c) && pend[c]) cfg_ready = 1'b0;
    end
    for (int unsigned c = 0; c < NumCh; c++) begin
      load[c] = cfg_valid && cfg_ready && (cfg_ch == ChW'(c));
    end
  end

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    nco_channel #(
      .AccWidth (AccWidth)
    ) u_ch (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en[g]),
      .cfg_load  (load[g]),
      .cfg_step  (cfg_step),
      .cfg_phase (cfg_phase),
      .cfg_mode  (mode_dec),
      .pending   (pend[g]),
      .clk_out   (clk_out[g]),
      .tick      (tick[g])
    );
  end

endmodule

// File: tb/tb_multi_freq_gen.sv
// Self-checking bench for multi_freq_gen (AccWidth=8, NumCh=2, ChW widened to
// 2 so out-of-range channel numbers can be driven).
module tb_multi_freq_gen;

  localparam int AW   = 8;
  localparam int NC   = 2;
  localparam int CW   = 2;
  localparam int FULL = 1 << AW;
  localparam int HALF = FULL / 2;

  logic          clk_in = 1'b0;
  logic          rst;
  logic [NC-1:0] en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [AW-1:0] cfg_step;
  logic [AW-1:0] cfg_phase;
  logic [1:0]    cfg_mode;
  logic [NC-1:0] clk_out;
  logic [NC-1:0] tick;

  multi_freq_gen #(
    .AccWidth (AW),
    .NumCh    (NC),
    .ChW      (CW)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_step  (cfg_step),
    .cfg_phase (cfg_phase),
    .cfg_mode  (cfg_mode),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int passed = 0;

  // Reference model: plain integers, mode 0 square, 1 pulse, 2 off.
  int m_acc [NC];
  int m_stp [NC];
  int m_ph  [NC];
  int m_md  [NC];
  int m_pstp[NC];
  int m_pph [NC];
  int m_pmd [NC];
  int m_pend[NC];
  logic [NC-1:0] e_clk;
  logic [NC-1:0] e_tick;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_acc[c] = 0; m_stp[c] = 0; m_ph[c] = 0; m_md[c] = 2;
      m_pstp[c] = 0; m_pph[c] = 0; m_pmd[c] = 2; m_pend[c] = 0;
    end
    e_clk  = '0;
    e_tick = '0;
  endtask

  // One clock: check ready, advance the model with the driven inputs, then
  // compare the registered outputs just after the edge.
  task automatic cyc();
    int exp_ready;
    int s;
    int wrap;
    int apply;
    #1;
    exp_ready = 1;
    if (int'(cfg_ch) < NC) begin
      if (m_pend[int'(cfg_ch)] != 0) exp_ready = 0;
    end
    chk("cfg_ready", int'(cfg_ready), exp_ready);
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < NC; c++) begin
        s    = m_acc[c] + m_stp[c];
        wrap = (s >= FULL) ? 1 : 0;
        if (en[c]) begin
          e_tick[c] = wrap[0];
          if (m_md[c] == 0)      e_clk[c] = (((m_acc[c] + m_ph[c]) % FULL) >= HALF);
          else if (m_md[c] == 1) e_clk[c] = wrap[0];
          else                   e_clk[c] = 1'b0;
          m_acc[c] = s % FULL;
        end else begin
          e_tick[c] = 1'b0;
          if (m_md[c] != 0) e_clk[c] = 1'b0;
        end
        apply = (m_pend[c] != 0) && (!en[c] || m_md[c] == 2 || m_stp[c] == 0 || wrap != 0);
        if (apply != 0) begin
          m_stp[c] = m_pstp[c]; m_ph[c] = m_pph[c]; m_md[c] = m_pmd[c];
          m_pend[c] = 0;
        end
        if (cfg_valid && exp_ready != 0 && int'(cfg_ch) == c) begin
          m_pstp[c] = int'(cfg_step);
          m_pph[c]  = int'(cfg_phase);
          m_pmd[c]  = (cfg_mode >= 2'd2) ? 2 : int'(cfg_mode);
          m_pend[c] = 1;
        end
      end
    end
    @(posedge clk_in);
    #1;
    chk("clk_out", int'(clk_out), int'(e_clk));
    chk("tick", int'(tick), int'(e_tick));
  endtask

  task automatic send(input int ch, input int step, input int phase, input int mode);
    cfg_valid = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_step  = AW'(step);
    cfg_phase = AW'(phase);
    cfg_mode  = 2'(mode);
    cyc();
    cfg_valid = 1'b0;
  endtask

  int cnt_t0, cnt_c0, cnt_c1;

  initial begin
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_step = '0; cfg_phase = '0; cfg_mode = 2'd0;
    model_reset();
    @(posedge clk_in); #1;
    cyc();
    rst = 1'b0;
    chk("reset clk_out", int'(clk_out), 0);
    chk("reset tick", int'(tick), 0);
    #1 chk("reset cfg_ready", int'(cfg_ready), 1);

    // ch0 square step 64, ch1 pulse step 128
    en = 2'b11;
    send(0, 64, 0, 0);
    send(1, 128, 0, 1);
    repeat (4) cyc();
    cnt_t0 = 0; cnt_c0 = 0; cnt_c1 = 0;
    repeat (16) begin
      cyc();
      cnt_t0 += int'(tick[0]);
      cnt_c0 += int'(clk_out[0]);
      cnt_c1 += int'(clk_out[1]);
    end
    chk("sq64 ticks/16", cnt_t0, 4);
    chk("sq64 high/16", cnt_c0, 8);
    chk("pulse128 high/16", cnt_c1, 8);

    // mid-period step change to 32
    repeat (1) cyc();
    send(0, 32, 0, 0);
    cfg_ch = '0;
    #1 chk("ready low while pending", int'(cfg_ready), 0);
    repeat (8) cyc();
    cnt_t0 = 0;
    repeat (32) begin
      cyc();
      cnt_t0 += int'(tick[0]);
    end
    chk("sq32 ticks/32", cnt_t0, 4);

    // phase offset 128 with step 64
    send(0, 64, 128, 0);
    repeat (20) cyc();

    // pause ch0
    en = 2'b10;
    cnt_t0 = 0;
    repeat (10) begin
      cyc();
      cnt_t0 += int'(tick[0]);
    end
    chk("paused ticks", cnt_t0, 0);
    en = 2'b11;
    repeat (12) cyc();

    // out-of-range channel is accepted and dropped
    send(3, 5, 5, 0);
    repeat (3) cyc();

    // reset with a pending config on ch1
    send(1, 10, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cfg_ch = CW'(1);
    chk("rst pending clk_out", int'(clk_out), 0);
    chk("rst pending tick", int'(tick), 0);
    #1 chk("rst pending ready", int'(cfg_ready), 1);
    repeat (8) cyc();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 5) == 0) ? NC'($urandom_range(0, 3)) : 2'b11;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = CW'($urandom_range(0, 3));
      cfg_step  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, FULL - 1));
      cfg_phase = AW'($urandom_range(0, FULL - 1));
      cfg_mode  = 2'($urandom_range(0, 3));
      cyc();
    end
    rst = 1'b0; cfg_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
